// File: rtl/time_tmr_replicate.sv
// Upstream stage of the time-redundant TMR path: re-issues each accepted element
// three times (or once in bypass) with a shared rolling ID and a replica index.
module time_tmr_replicate #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic [1:0]        replica_o,
  output logic              valid_o,
  input  logic              ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2,
    SEND2 = 2'd3
  } state_e;

  state_e            state_r;
  logic              tmr_r;
  logic [IDSize-1:0] id_cnt_r;
  logic              last_copy_s;
  logic              accept_s;

  // Upstream handshake: a new element may enter only when the last copy leaves.
  always_comb begin
    last_copy_s = 1'b0;
    case (state_r)
      SEND0:   last_copy_s = !tmr_r;
      SEND2:   last_copy_s = tmr_r;
      default: last_copy_s = 1'b0;
    endcase
    ready_o  = !rst_i && ((state_r == IDLE) || (last_copy_s && ready_i));
    accept_s = valid_i && ready_o;
  end

  // Replication FSM; an accept always preloads SEND0, so the last copy chains with no bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      tmr_r     <= 1'b0;
      id_cnt_r  <= '0;
      data_o    <= '0;
      id_o      <= '0;
      replica_o <= 2'd0;
      valid_o   <= 1'b0;
    end else if (accept_s) begin
      state_r   <= SEND0;
      tmr_r     <= enable_i;
      data_o    <= data_i;
      id_o      <= id_cnt_r;
      id_cnt_r  <= id_cnt_r + IDSize'(1);
      replica_o <= 2'd0;
      valid_o   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
        end
        SEND0: begin
          if (ready_i && tmr_r) begin
            state_r   <= SEND1;
            replica_o <= 2'd1;
          end else if (ready_i) begin
            state_r <= IDLE;
            valid_o <= 1'b0;
          end else begin
            state_r <= SEND0;
          end
        end
        SEND1: begin
          if (ready_i) begin
            state_r   <= SEND2;
            replica_o <= 2'd2;
          end else begin
            state_r <= SEND1;
          end
        end
        SEND2: begin
          if (ready_i) begin
            state_r <= IDLE;
            valid_o <= 1'b0;
          end else begin
            state_r <= SEND2;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_tmr_replicate.sv
// Directed bench for time_tmr_replicate: inputs driven and outputs sampled on the falling edge.
module tb_time_tmr_replicate;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic [3:0] id_out;
  logic [1:0] replica_out;
  logic       valid_out;
  logic       ready_in;

  int n_assert = 0;
  int n_fail   = 0;

  time_tmr_replicate #(
    .DataType (logic [7:0]),
    .IDSize   (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (enable),
    .data_i    (data_in),
    .valid_i   (valid_in),
    .ready_o   (ready_out),
    .data_o    (data_out),
    .id_o      (id_out),
    .replica_o (replica_out),
    .valid_o   (valid_out),
    .ready_i   (ready_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic [7:0] id,
                          input logic [7:0] rep);
    chk({tag, ".valid"},   8'(valid_out),   8'd1);
    chk({tag, ".data"},    data_out,        d);
    chk({tag, ".id"},      8'(id_out),      id);
    chk({tag, ".replica"}, 8'(replica_out), rep);
  endtask

  initial begin
    // 1: reset holds everything idle even with valid asserted
    rst = 1'b1; enable = 1'b1; data_in = 8'h00; valid_in = 1'b1; ready_in = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst.ready",   8'(ready_out),   8'd0);
    chk("rst.valid",   8'(valid_out),   8'd0);
    chk("rst.data",    data_out,        8'h00);
    chk("rst.id",      8'(id_out),      8'd0);
    chk("rst.replica", 8'(replica_out), 8'd0);
    valid_in = 1'b0; rst = 1'b0;
    #1;
    chk("idle.ready", 8'(ready_out), 8'd1);

    // 2: single TMR element; enable changed after accept must not matter
    @(negedge clk);
    data_in = 8'hA5; enable = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; enable = 1'b0;
    chk_beat("single.r0", 8'hA5, 8'd0, 8'd0);
    chk("single.r0.ready", 8'(ready_out), 8'd0);
    @(negedge clk);
    chk_beat("single.r1", 8'hA5, 8'd0, 8'd1);
    chk("single.r1.ready", 8'(ready_out), 8'd0);
    @(negedge clk);
    chk_beat("single.r2", 8'hA5, 8'd0, 8'd2);
    chk("single.r2.ready", 8'(ready_out), 8'd1);
    @(negedge clk);
    chk("single.end.valid", 8'(valid_out), 8'd0);

    // 3: back-to-back elements after a fresh reset -> 9 contiguous beats
    rst = 1'b1; #1; rst = 1'b0;
    enable = 1'b1; data_in = 8'h01; valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk_beat("b2b", 8'(1 + i / 3), 8'(i / 3), 8'(i % 3));
      chk("b2b.ready", 8'(ready_out), ((i % 3) == 2) ? 8'd1 : 8'd0);
      if ((i % 3) == 2) begin
        if (i < 8) data_in = 8'(2 + i / 3);
        else valid_in = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b.end.valid", 8'(valid_out), 8'd0);

    // 4: backpressure while replica 1 is shown
    data_in = 8'h77; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk_beat("bp.r0", 8'h77, 8'd3, 8'd0);
    @(negedge clk);
    chk_beat("bp.r1", 8'h77, 8'd3, 8'd1);
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_beat("bp.hold", 8'h77, 8'd3, 8'd1);
      chk("bp.hold.ready", 8'(ready_out), 8'd0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk_beat("bp.r2", 8'h77, 8'd3, 8'd2);
    @(negedge clk);
    chk("bp.end.valid", 8'(valid_out), 8'd0);

    // 5: ID wrap with 17 bypass elements streamed one per cycle
    rst = 1'b1; #1; rst = 1'b0;
    enable = 1'b0; data_in = 8'h00; valid_in = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk_beat("wrap", 8'(k), 8'(k % 16), 8'd0);
      chk("wrap.ready", 8'(ready_out), 8'd1);
      if (k < 16) data_in = 8'(k + 1);
      else valid_in = 1'b0;
    end
    @(negedge clk);
    chk("wrap.end.valid", 8'(valid_out), 8'd0);

    // 6a: single bypass element; ID keeps counting from the wrap
    data_in = 8'h3C; enable = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; enable = 1'b1;
    chk_beat("byp", 8'h3C, 8'd1, 8'd0);
    chk("byp.ready", 8'(ready_out), 8'd1);
    @(negedge clk);
    chk("byp.end.valid", 8'(valid_out), 8'd0);

    // 6b: reset during replica 1 discards remaining copies and restarts IDs
    data_in = 8'h5A; enable = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk_beat("rmid.r0", 8'h5A, 8'd2, 8'd0);
    @(negedge clk);
    chk_beat("rmid.r1", 8'h5A, 8'd2, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid.valid",   8'(valid_out),   8'd0);
    chk("rmid.ready",   8'(ready_out),   8'd0);
    chk("rmid.data",    data_out,        8'h00);
    chk("rmid.replica", 8'(replica_out), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rmid.after.valid", 8'(valid_out), 8'd0);
    end
    data_in = 8'hC3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk_beat("rmid.new", 8'hC3, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rmid.new.end.valid", 8'(valid_out), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
